// File: rtl/ipm_decode_seq_if.sv
// Bus bundle for the IPM decoder: share-vector input handshake and decoded-byte output handshake.
// The master side drives L/M/in_valid/out_ready; the decoder (slave) drives in_ready/X/out_valid.
interface ipm_decode_seq_if #(
    parameter int v = 8
);
    logic [v*8-1:0] L;
    logic [v*8-1:0] M;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     X;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output L, M, in_valid, out_ready,
        input  in_ready, X, out_valid
    );

    modport slave (
        input  L, M, in_valid, out_ready,
        output in_ready, X, out_valid
    );
endinterface

// File: rtl/ipm_decode_seq.sv
// Sequential IPM decoder: X = XOR over i of gfmul(L[i], M[i]) in GF(2^8), one MAC per cycle.
// Optional macro IPM_DECODE_ZEROIZE_EN clears captured shares, accumulator and X after each handshake.
module ipm_decode_seq #(
    parameter int          v    = 8,
    parameter logic [7:0]  POLY = 8'h1B
) (
    input  logic               clk,
    input  logic               rst,
    ipm_decode_seq_if.slave    bus,
    output logic [1:0]         dbg_state
);
    // Both handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid is not withdrawn by the decoder before out_ready, and in_ready is high only in IDLE.
    localparam int IW = (v > 1) ? $clog2(v) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      acc_q, acc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      lc_q [v];
    logic [7:0]      lc_d [v];
    logic [7:0]      mc_q [v];
    logic [7:0]      mc_d [v];
    logic [7:0]      x_q, x_d;
    logic [7:0]      prod;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ POLY) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    assign prod          = gf_mul(lc_q[idx_q], mc_q[idx_q]);
    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.X         = x_q;
    assign dbg_state     = state_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        lc_d    = lc_q;
        mc_d    = mc_q;
        x_d     = x_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < v; i++) begin
                        lc_d[i] = bus.L[8*i +: 8];
                        mc_d[i] = bus.M[8*i +: 8];
                    end
                    acc_d   = 8'h00;
                    idx_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q ^ prod;
                idx_d = idx_q + 1'b1;
                if (idx_q == IW'(v - 1)) begin
                    x_d     = acc_q ^ prod;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
`ifdef IPM_DECODE_ZEROIZE_EN
                    for (int i = 0; i < v; i++) begin
                        lc_d[i] = 8'h00;
                        mc_d[i] = 8'h00;
                    end
                    acc_d = 8'h00;
                    x_d   = 8'h00;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= 8'h00;
            idx_q   <= '0;
            x_q     <= 8'h00;
            for (int i = 0; i < v; i++) begin
                lc_q[i] <= 8'h00;
                mc_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            lc_q    <= lc_d;
            mc_q    <= mc_d;
        end
    end
endmodule

// File: tb/tb_ipm_decode_seq.sv
// Bench for ipm_decode_seq: a v=2 and a v=8 instance checked against a carry-less-product reference.
module tb_ipm_decode_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ipm_decode_seq_if #(.v(2)) bus2();
  ipm_decode_seq_if #(.v(8)) bus8();
  logic [1:0] dbg2;
  logic [1:0] dbg8;

  ipm_decode_seq #(.v(2), .POLY(8'h1B)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2));
  ipm_decode_seq #(.v(8), .POLY(8'h1B)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .dbg_state(dbg8));

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  // Reference: full 15-bit carry-less product, then long division by x^8 + 0x1B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    logic [14:0] red;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) begin
      red = 15'h11B << (k - 8);
      if (p[k]) p = p ^ red;
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_decode(input logic [63:0] l, input logic [63:0] m, input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < n; i++) s = s ^ ref_mul(l[8*i +: 8], m[8*i +: 8]);
    return s;
  endfunction

  function automatic logic ov(input int sel);
    return (sel == 8) ? bus8.out_valid : bus2.out_valid;
  endfunction
  function automatic logic ir(input int sel);
    return (sel == 8) ? bus8.in_ready : bus2.in_ready;
  endfunction
  function automatic logic [7:0] xo(input int sel);
    return (sel == 8) ? bus8.X : bus2.X;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic [63:0] l, input logic [63:0] m, input logic vld);
    if (sel == 8) begin
      bus8.L = l; bus8.M = m; bus8.in_valid = vld;
    end else begin
      bus2.L = l[15:0]; bus2.M = m[15:0]; bus2.in_valid = vld;
    end
  endtask

  task automatic set_or(input int sel, input logic r);
    if (sel == 8) bus8.out_ready = r;
    else bus2.out_ready = r;
  endtask

  // Accept one vector, then wait (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic start_decode(input int sel, input logic [63:0] l, input logic [63:0] m,
                              input bit perturb, output int lat);
    set_in(sel, l, m, 1'b1);
    tick();
    set_in(sel, l, m, 1'b0);
    checks++;
    if (ir(sel) !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_accept v=%0d in_ready=%b expected 0", sel, ir(sel));
    end
    lat = 0;
    while (ov(sel) !== 1'b1 && lat < 40) begin
      if (perturb) set_in(sel, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      tick();
      lat++;
    end
    if (ov(sel) !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_timeout v=%0d waited=%0d cycles", sel, lat);
    end
  endtask

  task automatic finish_decode(input int sel);
    set_or(sel, 1'b1);
    tick();
    set_or(sel, 1'b0);
    checks++;
    if (ov(sel) !== 1'b0 || ir(sel) !== 1'b1) begin
      failures++;
      $display("FAIL release_to_idle v=%0d out_valid=%b in_ready=%b expected 0/1", sel, ov(sel), ir(sel));
    end
  endtask

  task automatic check_result(input string name, input int sel, input int lat, input int exp_lat,
                              input logic [7:0] exp_x);
    checks++;
    if (xo(sel) !== exp_x) begin
      failures++;
      $display("FAIL %s X=%h expected %h", name, xo(sel), exp_x);
    end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d expected %0d", name, lat, exp_lat);
    end
  endtask

  task automatic test_reset();
    int lat;
    int seen;
    rst = 1'b1;
    set_in(2, '0, '0, 1'b0); set_in(8, '0, '0, 1'b0);
    set_or(2, 1'b0); set_or(8, 1'b0);
    tick(); tick();
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.X !== 8'h00 ||
        bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0 || bus2.X !== 8'h00) begin
      failures++;
      $display("FAIL reset_values rdy=%b/%b vld=%b/%b X=%h/%h expected 1/1 0/0 00/00",
               bus8.in_ready, bus2.in_ready, bus8.out_valid, bus2.out_valid, bus8.X, bus2.X);
    end
    rst = 1'b0;
    // out_ready while idle must not do anything
    set_or(8, 1'b1);
    tick(); tick();
    set_or(8, 1'b0);
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_out_ready out_valid=%b in_ready=%b expected 0/1", bus8.out_valid, bus8.in_ready);
    end
    // leave a nonzero X behind, then reset in the middle of the next ACCUM
    start_decode(8, 64'h01, 64'h5A, 1'b0, lat);
    finish_decode(8);
    set_in(8, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    tick();
    set_in(8, '0, '0, 1'b0);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.X !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_mid_accum out_valid=%b in_ready=%b X=%h expected 0/1/00",
               bus8.out_valid, bus8.in_ready, bus8.X);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL no_output_after_reset out_valid high for %0d cycles expected 0", seen);
    end
  endtask

  task automatic test_directed_v2();
    int lat;
    start_decode(2, 64'h5701, 64'h8310, 1'b0, lat);
    check_result("v2_d1", 2, lat, 2, 8'hD1);
    finish_decode(2);
    start_decode(2, 64'h1357, 64'h0000, 1'b0, lat);
    check_result("v2_zero_shares", 2, lat, 2, 8'h00);
    finish_decode(2);
    start_decode(2, 64'h1300, 64'h5700, 1'b0, lat);
    check_result("v2_fe", 2, lat, 2, 8'hFE);
    finish_decode(2);
  endtask

  task automatic test_input_isolation();
    int lat;
    start_decode(8, 64'h0101010101010101, 64'h0102040810204080, 1'b0, lat);
    check_result("v8_ones", 8, lat, 8, 8'hFF);
    finish_decode(8);
    start_decode(8, 64'h0101010101010101, 64'h0102040810204080, 1'b1, lat);
    check_result("v8_ones_perturbed", 8, lat, 8, 8'hFF);
    finish_decode(8);
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] l;
    logic [63:0] m;
    logic [7:0] e;
    l = {$urandom, $urandom};
    m = {$urandom, $urandom};
    e = ref_decode(l, m, 8);
    start_decode(8, l, m, 1'b0, lat);
    check_result("bp_result", 8, lat, 8, e);
    for (int c = 0; c < 5; c++) begin
      set_in(8, {$urandom, $urandom}, {$urandom, $urandom}, c[0]);
      tick();
      checks++;
      if (bus8.X !== e || bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d X=%h vld=%b rdy=%b expected %h/1/0",
                 c, bus8.X, bus8.out_valid, bus8.in_ready, e);
      end
    end
    set_in(8, '0, '0, 1'b0);
    finish_decode(8);
  endtask

  task automatic test_back_to_back();
    int lat;
    int n;
    logic [63:0] l;
    logic [63:0] m;
    logic [7:0] got;
    for (int t = 0; t < 24; t++) begin
      n = (t % 3 == 0) ? 2 : 8;
      l = {$urandom, $urandom};
      m = {$urandom, $urandom};
      exp_q.push_back(ref_decode(l, m, n));
      start_decode(n, l, m, 1'b0, lat);
      for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
      got = xo(n);
      checks++;
      if (got !== exp_q[0] || lat != n) begin
        failures++;
        $display("FAIL random_decode t=%0d v=%0d X=%h lat=%0d expected %h lat=%0d",
                 t, n, got, lat, exp_q[0], n);
      end
      void'(exp_q.pop_front());
      finish_decode(n);
    end
  endtask

  task automatic test_zeroize();
    int lat;
    logic [7:0] e;
    e = ref_mul(8'h01, 8'(($urandom_range(1, 255))));
    start_decode(8, 64'h01, {56'h0, e}, 1'b0, lat);
    check_result("zeroize_pre", 8, lat, 8, e);
    finish_decode(8);
    tick();
    checks++;
`ifdef IPM_DECODE_ZEROIZE_EN
    if (bus8.X !== 8'h00) begin
      failures++;
      $display("FAIL zeroize_x X=%h expected 00", bus8.X);
    end
`else
    if (bus8.X !== e) begin
      failures++;
      $display("FAIL x_retained X=%h expected %h", bus8.X, e);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed_v2();
    test_input_isolation();
    test_backpressure();
    test_back_to_back();
    test_zeroize();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
